// File: rtl/id_ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module : id_ex_stage_pkg
// Brief  : ALU control codes, forwarding-select type and selection helper
//          shared by the ID/EX stage and its forwarding unit.
// Rev    : 1.0
// ============================================================================
package id_ex_stage_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [1:0] {
        FWD_RF  = 2'd0,
        FWD_MEM = 2'd1,
        FWD_WB  = 2'd2
    } fwd_sel_t;

    // MEM holds the younger result, so it outranks WB.
    function automatic fwd_sel_t fwd_pick(input logic mem_hit, input logic wb_hit);
        fwd_sel_t sel;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_stage_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module : id_ex_stage_fwd_unit
// Brief  : Combinational RAW-hazard forwarding select for the EX rs/rt operands.
// Rev    : 1.0
// ============================================================================
module id_ex_stage_fwd_unit
    import id_ex_stage_pkg::*;
#(
    parameter int REGW = 5
) (
    input  logic [REGW-1:0] ex_rs,
    input  logic [REGW-1:0] ex_rt,
    input  logic            mem_regwrite,
    input  logic [REGW-1:0] mem_waddr,
    input  logic            wb_regwrite,
    input  logic [REGW-1:0] wb_waddr,
    output fwd_sel_t        fwd_rs_sel,
    output fwd_sel_t        fwd_rt_sel
);

    logic w_rs_mem_hit;
    logic w_rs_wb_hit;
    logic w_rt_mem_hit;
    logic w_rt_wb_hit;

    // Register 0 is hard-wired to zero and never takes a forwarded value.
    always_comb begin
        w_rs_mem_hit = mem_regwrite && (mem_waddr == ex_rs) && (ex_rs != '0);
        w_rs_wb_hit  = wb_regwrite  && (wb_waddr  == ex_rs) && (ex_rs != '0);
        w_rt_mem_hit = mem_regwrite && (mem_waddr == ex_rt) && (ex_rt != '0);
        w_rt_wb_hit  = wb_regwrite  && (wb_waddr  == ex_rt) && (ex_rt != '0);
        fwd_rs_sel   = fwd_pick(w_rs_mem_hit, w_rs_wb_hit);
        fwd_rt_sel   = fwd_pick(w_rt_mem_hit, w_rt_wb_hit);
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module : id_ex_stage
// Brief  : ID/EX pipeline register with load-use bubble insertion and
//          MEM/WB operand forwarding into the ALU inputs.
// Rev    : 1.0
// ============================================================================
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int N    = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [N-1:0]    id_rd1,
    input  logic [N-1:0]    id_rd2,
    input  logic [N-1:0]    id_imm,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_alusrc,
    input  logic            id_regdst,
    input  logic [2:0]      id_alucont,
    input  logic            id_regwrite,
    input  logic            id_memwrite,
    input  logic            id_memtoreg,
    input  logic            mem_regwrite,
    input  logic [REGW-1:0] mem_waddr,
    input  logic [N-1:0]    mem_result,
    input  logic            wb_regwrite,
    input  logic [REGW-1:0] wb_waddr,
    input  logic [N-1:0]    wb_result,
    output logic            load_use_stall,
    output logic [N-1:0]    alu_a,
    output logic [N-1:0]    alu_b,
    output logic [2:0]      alu_cont,
    output logic [N-1:0]    ex_writedata,
    output logic [REGW-1:0] ex_waddr,
    output logic            ex_valid,
    output logic            ex_regwrite,
    output logic            ex_memwrite,
    output logic            ex_memtoreg
);

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memwrite;
        logic            memtoreg;
        logic            alusrc;
        logic [2:0]      alucont;
        logic [N-1:0]    rd1;
        logic [N-1:0]    rd2;
        logic [N-1:0]    imm;
        logic [REGW-1:0] rs;
        logic [REGW-1:0] rt;
        logic [REGW-1:0] waddr;
    } id_ex_t;

    id_ex_t     stage_d;
    id_ex_t     stage_q;
    id_ex_t     w_bubble;
    id_ex_t     w_capture;
    fwd_sel_t   w_rs_sel;
    fwd_sel_t   w_rt_sel;
    logic [N-1:0] w_fwd_rs;
    logic [N-1:0] w_fwd_rt;

    always_comb begin
        w_bubble         = '0;
        w_bubble.alucont = ALU_ADD;

        w_capture.valid    = id_valid;
        w_capture.regwrite = id_valid & id_regwrite;
        w_capture.memwrite = id_valid & id_memwrite;
        w_capture.memtoreg = id_valid & id_memtoreg;
        w_capture.alusrc   = id_alusrc;
        w_capture.alucont  = id_alucont;
        w_capture.rd1      = id_rd1;
        w_capture.rd2      = id_rd2;
        w_capture.imm      = id_imm;
        w_capture.rs       = id_rs;
        w_capture.rt       = id_rt;
        w_capture.waddr    = id_regdst ? id_rd : id_rt;
    end

    assign load_use_stall = stage_q.valid && stage_q.memtoreg && (stage_q.waddr != '0) &&
                            id_valid && ((stage_q.waddr == id_rs) || (stage_q.waddr == id_rt));

    always_comb begin
        stage_d = w_capture;
        if (flush) begin
            stage_d = w_bubble;
        end else if (stall) begin
            stage_d = stage_q;
        end else if (load_use_stall) begin
            stage_d = w_bubble;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_q <= w_bubble;
        end else begin
            stage_q <= stage_d;
        end
    end

    id_ex_stage_fwd_unit #(
        .REGW (REGW)
    ) u_fwd_unit (
        .ex_rs        (stage_q.rs),
        .ex_rt        (stage_q.rt),
        .mem_regwrite (mem_regwrite),
        .mem_waddr    (mem_waddr),
        .wb_regwrite  (wb_regwrite),
        .wb_waddr     (wb_waddr),
        .fwd_rs_sel   (w_rs_sel),
        .fwd_rt_sel   (w_rt_sel)
    );

    always_comb begin
        case (w_rs_sel)
            FWD_MEM: w_fwd_rs = mem_result;
            FWD_WB:  w_fwd_rs = wb_result;
            default: w_fwd_rs = stage_q.rd1;
        endcase
        case (w_rt_sel)
            FWD_MEM: w_fwd_rt = mem_result;
            FWD_WB:  w_fwd_rt = wb_result;
            default: w_fwd_rt = stage_q.rd2;
        endcase
    end

    assign alu_a        = w_fwd_rs;
    assign alu_b        = stage_q.alusrc ? stage_q.imm : w_fwd_rt;
    assign ex_writedata = w_fwd_rt;
    assign alu_cont     = stage_q.alucont;
    assign ex_waddr     = stage_q.waddr;
    assign ex_valid     = stage_q.valid;
    assign ex_regwrite  = stage_q.regwrite;
    assign ex_memwrite  = stage_q.memwrite;
    assign ex_memtoreg  = stage_q.memtoreg;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_id_ex_stage
// Brief  : Scoreboard bench for id_ex_stage: directed scenarios plus random
//          traffic compared against an instruction-level reference model.
// Rev    : 1.0
// ============================================================================
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam int N    = 32;
    localparam int REGW = 5;

    logic            clk = 1'b0;
    logic            reset, stall, flush, id_valid;
    logic [N-1:0]    id_rd1, id_rd2, id_imm;
    logic [REGW-1:0] id_rs, id_rt, id_rd;
    logic            id_alusrc, id_regdst;
    logic [2:0]      id_alucont;
    logic            id_regwrite, id_memwrite, id_memtoreg;
    logic            mem_regwrite;
    logic [REGW-1:0] mem_waddr;
    logic [N-1:0]    mem_result;
    logic            wb_regwrite;
    logic [REGW-1:0] wb_waddr;
    logic [N-1:0]    wb_result;
    logic            load_use_stall;
    logic [N-1:0]    alu_a, alu_b, ex_writedata;
    logic [2:0]      alu_cont;
    logic [REGW-1:0] ex_waddr;
    logic            ex_valid, ex_regwrite, ex_memwrite, ex_memtoreg;

    always #5 clk = ~clk;

    id_ex_stage #(.N(N), .REGW(REGW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_alucont(id_alucont),
        .id_regwrite(id_regwrite), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .mem_regwrite(mem_regwrite), .mem_waddr(mem_waddr), .mem_result(mem_result),
        .wb_regwrite(wb_regwrite), .wb_waddr(wb_waddr), .wb_result(wb_result),
        .load_use_stall(load_use_stall), .alu_a(alu_a), .alu_b(alu_b), .alu_cont(alu_cont),
        .ex_writedata(ex_writedata), .ex_waddr(ex_waddr), .ex_valid(ex_valid),
        .ex_regwrite(ex_regwrite), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg)
    );

    typedef struct packed {
        logic            reset, stall, flush, id_valid;
        logic [N-1:0]    rd1, rd2, imm;
        logic [REGW-1:0] rs, rt, rd;
        logic            alusrc, regdst;
        logic [2:0]      alucont;
        logic            regwrite, memwrite, memtoreg;
        logic            mem_regwrite;
        logic [REGW-1:0] mem_waddr;
        logic [N-1:0]    mem_result;
        logic            wb_regwrite;
        logic [REGW-1:0] wb_waddr;
        logic [N-1:0]    wb_result;
    } in_t;

    // The instruction occupying EX, as the model sees it.
    typedef struct packed {
        logic            valid, regwrite, memwrite, memtoreg, alusrc;
        logic [2:0]      alucont;
        logic [N-1:0]    rd1, rd2, imm;
        logic [REGW-1:0] rs, rt, waddr;
    } ex_t;

    typedef struct packed {
        logic            lus;
        logic            full;
        logic            valid, regwrite, memwrite, memtoreg;
        logic [2:0]      alucont;
        logic [N-1:0]    a, b, wd;
        logic [REGW-1:0] waddr;
    } exp_t;

    exp_t sb[$];
    ex_t  m;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    function automatic ex_t empty_slot();
        ex_t s;
        s = '0;
        s.alucont = ALU_ADD;
        return s;
    endfunction

    function automatic logic [N-1:0] operand(input logic [REGW-1:0] r, input logic [N-1:0] rf, input in_t x);
        if (r != 0 && x.mem_regwrite && x.mem_waddr == r) return x.mem_result;
        if (r != 0 && x.wb_regwrite && x.wb_waddr == r) return x.wb_result;
        return rf;
    endfunction

    function automatic in_t nop_in();
        in_t x;
        x = '0;
        x.alucont = ALU_ADD;
        return x;
    endfunction

    function automatic in_t rand_in();
        in_t x;
        x.reset        = ($urandom_range(0, 49) == 0);
        x.stall        = ($urandom_range(0, 9) == 0);
        x.flush        = ($urandom_range(0, 19) == 0);
        x.id_valid     = ($urandom_range(0, 9) != 0);
        x.rd1          = $urandom;
        x.rd2          = $urandom;
        x.imm          = $urandom;
        x.rs           = REGW'($urandom_range(0, 7));
        x.rt           = REGW'($urandom_range(0, 7));
        x.rd           = REGW'($urandom_range(0, 7));
        x.alusrc       = 1'($urandom_range(0, 1));
        x.regdst       = 1'($urandom_range(0, 1));
        x.alucont      = 3'($urandom_range(0, 7));
        x.regwrite     = 1'($urandom_range(0, 1));
        x.memwrite     = 1'($urandom_range(0, 1));
        x.memtoreg     = ($urandom_range(0, 2) == 0);
        x.mem_regwrite = 1'($urandom_range(0, 1));
        x.mem_waddr    = REGW'($urandom_range(0, 7));
        x.mem_result   = $urandom;
        x.wb_regwrite  = 1'($urandom_range(0, 1));
        x.wb_waddr     = REGW'($urandom_range(0, 7));
        x.wb_result    = $urandom;
        return x;
    endfunction

    // Drive one cycle of inputs and record what the model expects from it.
    task automatic apply(input in_t x);
        ex_t  nxt;
        exp_t e;
        logic hazard;
        @(negedge clk);
        reset = x.reset; stall = x.stall; flush = x.flush; id_valid = x.id_valid;
        id_rd1 = x.rd1; id_rd2 = x.rd2; id_imm = x.imm;
        id_rs = x.rs; id_rt = x.rt; id_rd = x.rd;
        id_alusrc = x.alusrc; id_regdst = x.regdst; id_alucont = x.alucont;
        id_regwrite = x.regwrite; id_memwrite = x.memwrite; id_memtoreg = x.memtoreg;
        mem_regwrite = x.mem_regwrite; mem_waddr = x.mem_waddr; mem_result = x.mem_result;
        wb_regwrite = x.wb_regwrite; wb_waddr = x.wb_waddr; wb_result = x.wb_result;

        hazard = m.valid && m.memtoreg && m.waddr != 0 && x.id_valid &&
                 (m.waddr == x.rs || m.waddr == x.rt);
        e.full = 1'b1;
        if (x.reset || x.flush) begin
            nxt = empty_slot();
        end else if (x.stall) begin
            nxt = m;
        end else if (hazard) begin
            nxt = empty_slot();
        end else begin
            nxt.valid    = x.id_valid;
            nxt.regwrite = x.id_valid && x.regwrite;
            nxt.memwrite = x.id_valid && x.memwrite;
            nxt.memtoreg = x.id_valid && x.memtoreg;
            nxt.alusrc   = x.alusrc;
            nxt.alucont  = x.alucont;
            nxt.rd1      = x.rd1;
            nxt.rd2      = x.rd2;
            nxt.imm      = x.imm;
            nxt.rs       = x.rs;
            nxt.rt       = x.rt;
            nxt.waddr    = x.regdst ? x.rd : x.rt;
            e.full       = x.id_valid;
        end
        if (x.stall && !x.reset && !x.flush) e.full = e.full && (m.valid || m.alucont == ALU_ADD);

        e.lus      = hazard;
        e.valid    = nxt.valid;
        e.regwrite = nxt.regwrite;
        e.memwrite = nxt.memwrite;
        e.memtoreg = nxt.memtoreg;
        e.alucont  = nxt.alucont;
        e.waddr    = nxt.waddr;
        e.a        = operand(nxt.rs, nxt.rd1, x);
        e.wd       = operand(nxt.rt, nxt.rd2, x);
        e.b        = nxt.alusrc ? nxt.imm : e.wd;
        m = nxt;
        sb.push_back(e);
    endtask

    // Monitor: load_use_stall is checked before the edge, registered outputs after it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() != 0) begin
                e = sb[0];
                chk("load_use_stall", 64'(load_use_stall), 64'(e.lus));
                @(posedge clk);
                #1;
                e = sb.pop_front();
                chk("ex_valid", 64'(ex_valid), 64'(e.valid));
                chk("ex_regwrite", 64'(ex_regwrite), 64'(e.regwrite));
                chk("ex_memwrite", 64'(ex_memwrite), 64'(e.memwrite));
                chk("ex_memtoreg", 64'(ex_memtoreg), 64'(e.memtoreg));
                chk("alu_a", 64'(alu_a), 64'(e.a));
                chk("ex_writedata", 64'(ex_writedata), 64'(e.wd));
                chk("ex_waddr", 64'(ex_waddr), 64'(e.waddr));
                if (e.full) begin
                    chk("alu_b", 64'(alu_b), 64'(e.b));
                    chk("alu_cont", 64'(alu_cont), 64'(e.alucont));
                end
            end
        end
    end

    initial begin
        in_t x, y;
        {reset, stall, flush, id_valid, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd} = '0;
        {id_alusrc, id_regdst, id_alucont, id_regwrite, id_memwrite, id_memtoreg} = '0;
        {mem_regwrite, mem_waddr, mem_result, wb_regwrite, wb_waddr, wb_result} = '0;
        reset = 1'b1;
        m = empty_slot();

        // Reset held two cycles with random ID traffic, the second one mid-stall.
        x = rand_in(); x.reset = 1'b1; x.stall = 1'b0; x.flush = 1'b0; apply(x);
        x = rand_in(); x.reset = 1'b1; x.stall = 1'b1; apply(x);

        // Plain capture.
        x = nop_in(); x.id_valid = 1'b1; x.rd1 = 5; x.rd2 = 7; x.regdst = 1'b1;
        x.rd = 3; x.rs = 1; x.rt = 2; x.regwrite = 1'b1;
        apply(x);

        // MEM beats WB, then WB alone while the register is held.
        x = nop_in(); x.id_valid = 1'b1; x.rs = 4; x.rt = 5; x.rd1 = 32'h44; x.rd2 = 32'h55;
        x.mem_regwrite = 1'b1; x.mem_waddr = 4; x.mem_result = 32'h11;
        x.wb_regwrite = 1'b1; x.wb_waddr = 4; x.wb_result = 32'h22;
        apply(x);
        x.stall = 1'b1; x.mem_regwrite = 1'b0;
        apply(x);

        // Register 0 is never forwarded.
        x = nop_in(); x.id_valid = 1'b1; x.rs = 0; x.rt = 0;
        x.mem_regwrite = 1'b1; x.mem_waddr = 0; x.mem_result = 32'hFF;
        x.wb_regwrite = 1'b1; x.wb_waddr = 0; x.wb_result = 32'hEE;
        apply(x);

        // Load-use: lw $8 in EX, consumer of $8 in ID, held for a second try.
        x = nop_in(); x.id_valid = 1'b1; x.regwrite = 1'b1; x.memtoreg = 1'b1; x.rt = 8; x.rs = 9;
        apply(x);
        y = nop_in(); y.id_valid = 1'b1; y.rs = 8; y.rt = 2; y.rd1 = 32'h1234; y.regwrite = 1'b1;
        apply(y);
        y.mem_regwrite = 1'b1; y.mem_waddr = 8; y.mem_result = 32'hCAFE;
        apply(y);

        // A store frozen by three stall cycles, then flush+stall squashes it.
        x = nop_in(); x.id_valid = 1'b1; x.memwrite = 1'b1; x.rs = 3; x.rt = 6;
        x.rd1 = $urandom; x.rd2 = $urandom;
        apply(x);
        for (int i = 0; i < 3; i++) begin
            y = rand_in(); y.reset = 1'b0; y.flush = 1'b0; y.stall = 1'b1;
            y.mem_regwrite = 1'b0; y.wb_regwrite = 1'b0;
            apply(y);
        end
        y = rand_in(); y.reset = 1'b0; y.stall = 1'b1; y.flush = 1'b1;
        apply(y);

        for (int i = 0; i < 400; i++) begin
            apply(rand_in());
        end

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
